// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions.
// Provides the machine word width, the Booth recoding operation type, the
// multiplier FSM state type and a small Booth-pair decode helper.
package cpu_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    BOOTH_NOP,
    BOOTH_ADD,
    BOOTH_SUB
  } booth_op_e;

  typedef enum logic {
    MUL_IDLE,
    MUL_RUN
  } mul_state_e;

  // Radix-2 Booth recoding of the {Q[0], q-1} pair.
  function automatic booth_op_e booth_decode(input logic q0, input logic qm1);
    booth_op_e op;
    op = BOOTH_NOP;
    unique case ({q0, qm1})
      2'b01:   op = BOOTH_ADD;
      2'b10:   op = BOOTH_SUB;
      default: op = BOOTH_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_mul32_if.sv
// Request/result bundle between the control unit and booth_mul32.
// Signals:
//   start - request a multiply (master -> slave)
//   a, b  - signed multiplicand / multiplier (master -> slave)
//   busy  - operation in progress (slave -> master)
//   done  - one-cycle pulse, hi/lo freshly updated (slave -> master)
//   hi,lo - product bits [63:32] / [31:0] (slave -> master)
interface booth_mul32_if;
  import cpu_pkg::*;

  logic              start;
  logic [WORD_W-1:0] a;
  logic [WORD_W-1:0] b;
  logic              busy;
  logic              done;
  logic [WORD_W-1:0] hi;
  logic [WORD_W-1:0] lo;

  modport master (
    output start, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, a, b,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/adder32.sv
// 32-bit ripple-style adder used as the ALU add/subtract engine.
// Ports:
//   a, b - addends
//   cin  - carry in
//   sum  - a + b + cin, low 32 bits
//   cout - carry out of bit 31
module adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'b0, cin};

endmodule

// File: rtl/booth_mul32.sv
// Sequential signed 32x32 radix-2 Booth multiplier, one iteration per clock.
// A single adder32 instance performs every add/subtract; a 33-bit accumulator
// keeps M = -2^31 exact.
// Ports:
//   clk   - rising-edge clock
//   clr_n - asynchronous active-low reset
//   bus   - slave side of booth_mul32_if (start/a/b in, busy/done/hi/lo out)
module booth_mul32
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W
) (
  input  logic          clk,
  input  logic          clr_n,
  booth_mul32_if.slave  bus
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  mul_state_e       r_state;
  mul_state_e       w_state_d;
  logic [WIDTH:0]   r_a;      // 33-bit accumulator
  logic [WIDTH-1:0] r_q;
  logic             r_qm1;
  logic [WIDTH-1:0] r_m;
  logic [CntW-1:0]  r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_accept;
  logic             w_last;
  booth_op_e        w_op;
  logic [WIDTH-1:0] w_add_b;
  logic             w_add_cin;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic [WIDTH:0]   w_a_new;
  logic [WIDTH:0]   w_a_shr;
  logic [WIDTH-1:0] w_q_shr;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= MUL_IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_accept  = 1'b0;
    w_last    = 1'b0;
    unique case (r_state)
      MUL_IDLE: begin
        if (bus.start) begin
          w_accept  = 1'b1;
          w_state_d = MUL_RUN;
        end
      end
      MUL_RUN: begin
        if (r_cnt == CntLast) begin
          w_last    = 1'b1;
          w_state_d = MUL_IDLE;
        end
      end
      default: w_state_d = MUL_IDLE;
    endcase
  end

  // ----------------------------------------------------------- Datapath
  always_comb begin
    w_op      = booth_decode(r_q[0], r_qm1);
    w_add_b   = '0;
    w_add_cin = 1'b0;
    unique case (w_op)
      BOOTH_ADD: w_add_b = r_m;
      BOOTH_SUB: begin
        w_add_b   = ~r_m;
        w_add_cin = 1'b1;
      end
      default: w_add_b = '0;
    endcase
  end

  adder32 u_adder (
    .a    (r_a[WIDTH-1:0]),
    .b    (w_add_b),
    .cin  (w_add_cin),
    .sum  (w_sum),
    .cout (w_cout)
  );

  // Bit 32 of a 33-bit add: sign(A) + sign-extension of b + carry from bit 31.
  assign w_a_new = {r_a[WIDTH] ^ w_add_b[WIDTH-1] ^ w_cout, w_sum};

  // Arithmetic right shift of {A, Q, q-1}.
  assign w_a_shr = {w_a_new[WIDTH], w_a_new[WIDTH:1]};
  assign w_q_shr = {w_a_new[0], r_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_a    <= '0;
      r_q    <= '0;
      r_qm1  <= 1'b0;
      r_m    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_hi   <= '0;
      r_lo   <= '0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_m    <= bus.a;
        r_q    <= bus.b;
        r_qm1  <= 1'b0;
        r_a    <= '0;
        r_cnt  <= '0;
        r_busy <= 1'b1;
      end else if (r_state == MUL_RUN) begin
        r_a   <= w_a_shr;
        r_q   <= w_q_shr;
        r_qm1 <= r_q[0];
        r_cnt <= r_cnt + CntW'(1);
        if (w_last) begin
          r_busy <= 1'b0;
          r_hi   <= w_a_shr[WIDTH-1:0];
          r_lo   <= w_q_shr;
        end
      end
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule
